// File: rtl/axis_txc_pkg.sv
// Shared constants for the TX control stream checker.
// Register offsets, CTRL bit positions, counter widths, FSM states.
package axis_txc_pkg;

  localparam logic [3:0] ADDR_CTRL     = 4'h0;
  localparam logic [3:0] ADDR_EXPECT   = 4'h4;
  localparam logic [3:0] ADDR_WORD_CNT = 4'h8;
  localparam logic [3:0] ADDR_STATUS   = 4'hC;

  localparam logic [1:0] IDX_CTRL     = ADDR_CTRL[3:2];
  localparam logic [1:0] IDX_EXPECT   = ADDR_EXPECT[3:2];
  localparam logic [1:0] IDX_WORD_CNT = ADDR_WORD_CNT[3:2];
  localparam logic [1:0] IDX_STATUS   = ADDR_STATUS[3:2];

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_CAP    = 2;
  localparam int CTRL_STICKY = 31;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int WORD_CNT_W  = 32;
  localparam int ERR_CNT_W   = 16;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic logic [31:0] apply_strb(
    input logic [31:0] cur,
    input logic [31:0] wdata,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_txc_lite_regs.sv
// AXI4-Lite slave for the checker: write/read FSMs and CTRL bits.
// EXPECT and the counters live in the top; this block muxes them.
module axis_txc_lite_regs
  import axis_txc_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              en,
  output logic              cap,
  output logic              clr,
  output logic              expect_wr,
  output logic [31:0]       expect_wdata,
  input  logic              sticky,
  input  logic [31:0]       expect_cur,
  input  logic [31:0]       word_cnt,
  input  logic [15:0]       err_cnt,
  input  logic [15:0]       frame_cnt
);

  wr_state_t   wr_state;
  wr_state_t   wr_next;
  rd_state_t   rd_state;
  rd_state_t   rd_next;
  logic        wr_fire;
  logic        rd_fire;
  logic        ctrl_wr;
  logic [1:0]  wr_idx;
  logic [1:0]  rd_idx;
  logic [31:0] ctrl_word;
  logic [31:0] rd_word;
  logic        unused_ok;

  assign wr_idx = awaddr[3:2];
  assign rd_idx = araddr[3:2];
  assign unused_ok = ^{awaddr, araddr};

  // Write FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_state <= W_IDLE;
    else     wr_state <= wr_next;
  end

  // AW and W are taken together in one cycle, then B is held
  always_comb begin
    wr_next = wr_state;
    awready = 1'b0;
    wready  = 1'b0;
    wr_fire = 1'b0;
    unique case (wr_state)
      W_IDLE: begin
        if (awvalid && wvalid) begin
          awready = 1'b1;
          wready  = 1'b1;
          wr_fire = 1'b1;
          wr_next = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) wr_next = W_IDLE;
      end
    endcase
  end

  assign bvalid = (wr_state == W_RESP);

  assign ctrl_wr = wr_fire && (wr_idx == IDX_CTRL) && wstrb[0];
  assign clr     = ctrl_wr && wdata[CTRL_CLR];

  assign expect_wr    = wr_fire && (wr_idx == IDX_EXPECT);
  assign expect_wdata = apply_strb(expect_cur, wdata, wstrb);

  // CTRL RW bits; all of them sit in byte 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en  <= 1'b0;
      cap <= 1'b0;
    end else if (ctrl_wr) begin
      en  <= wdata[CTRL_EN];
      cap <= wdata[CTRL_CAP];
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_state <= R_IDLE;
    else     rd_state <= rd_next;
  end

  // AR accepted in idle, data then held until RREADY
  always_comb begin
    rd_next = rd_state;
    arready = 1'b0;
    rd_fire = 1'b0;
    unique case (rd_state)
      R_IDLE: begin
        if (arvalid) begin
          arready = 1'b1;
          rd_fire = 1'b1;
          rd_next = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) rd_next = R_IDLE;
      end
    endcase
  end

  assign rvalid = (rd_state == R_DATA);

  // CTRL readback image; CLR always reads as zero
  always_comb begin
    ctrl_word              = '0;
    ctrl_word[CTRL_EN]     = en;
    ctrl_word[CTRL_CAP]    = cap;
    ctrl_word[CTRL_STICKY] = sticky;
  end

  // Register read mux
  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      rd_idx == IDX_CTRL:     rd_word = ctrl_word;
      rd_idx == IDX_EXPECT:   rd_word = expect_cur;
      rd_idx == IDX_WORD_CNT: rd_word = word_cnt;
      rd_idx == IDX_STATUS:   rd_word = {frame_cnt, err_cnt};
      default:                rd_word = '0;
    endcase
  end

  // Read data captured at the address handshake and held
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rdata <= '0;
    else if (rd_fire) rdata <= rd_word;
  end

endmodule

// File: rtl/axis_txc_checker.sv
// AXI4-Stream sink checking TX control words against a running count.
// Holds the compare logic, EXPECT register and saturating counters.
module axis_txc_checker
  import axis_txc_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_S_AXI_ADDR_WIDTH   = 4,
  parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                            S_AXIS_TLAST,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY
);

  logic                   en;
  logic                   cap;
  logic                   clr;
  logic                   expect_wr;
  logic [31:0]            expect_wdata;
  logic [31:0]            expect_q;
  logic                   sticky;
  logic [WORD_CNT_W-1:0]  word_cnt;
  logic [ERR_CNT_W-1:0]   err_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   accept;
  logic                   mismatch;
  logic                   unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXIS_TREADY = en;

  assign accept   = S_AXIS_TVALID && S_AXIS_TREADY;
  assign mismatch = !cap && (S_AXIS_TDATA != expect_q);

  axis_txc_lite_regs #(
    .ADDR_W (C_S_AXI_ADDR_WIDTH)
  ) u_regs (
    .clk          (ACLK),
    .rst          (ARESET),
    .awaddr       (S_AXI_AWADDR),
    .awvalid      (S_AXI_AWVALID),
    .awready      (S_AXI_AWREADY),
    .wdata        (S_AXI_WDATA),
    .wstrb        (S_AXI_WSTRB),
    .wvalid       (S_AXI_WVALID),
    .wready       (S_AXI_WREADY),
    .bvalid       (S_AXI_BVALID),
    .bready       (S_AXI_BREADY),
    .araddr       (S_AXI_ARADDR),
    .arvalid      (S_AXI_ARVALID),
    .arready      (S_AXI_ARREADY),
    .rdata        (S_AXI_RDATA),
    .rvalid       (S_AXI_RVALID),
    .rready       (S_AXI_RREADY),
    .en           (en),
    .cap          (cap),
    .clr          (clr),
    .expect_wr    (expect_wr),
    .expect_wdata (expect_wdata),
    .sticky       (sticky),
    .expect_cur   (expect_q),
    .word_cnt     (word_cnt),
    .err_cnt      (err_cnt),
    .frame_cnt    (frame_cnt)
  );

  // Next expected word: software load wins, else resync to TDATA+1
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      expect_q <= '0;
    end else if (expect_wr) begin
      expect_q <= expect_wdata;
    end else if (accept && !clr) begin
      expect_q <= S_AXIS_TDATA + 32'd1;
    end
  end

  // Saturating counters and sticky error; a clear drops the beat
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      word_cnt  <= '0;
      err_cnt   <= '0;
      frame_cnt <= '0;
      sticky    <= 1'b0;
    end else if (clr) begin
      word_cnt  <= '0;
      err_cnt   <= '0;
      frame_cnt <= '0;
      sticky    <= 1'b0;
    end else if (accept) begin
      if (word_cnt != '1)
        word_cnt <= word_cnt + WORD_CNT_W'(1);
      if (S_AXIS_TLAST && (frame_cnt != '1))
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      if (mismatch) begin
        sticky <= 1'b1;
        if (err_cnt != '1)
          err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_txc_checker.sv
// Randomized scoreboard bench for axis_txc_checker.
// Reads queue expected data; a monitor pops on each R handshake.
`timescale 1ns/1ps
module tb_axis_txc_checker;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  AWADDR = '0;
  logic [2:0]  AWPROT = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [3:0]  ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [31:0] TDATA = '0;
  logic        TLAST = 1'b0;
  logic        TVALID = 1'b0;
  logic        TREADY;

  always #5 ACLK = ~ACLK;

  axis_txc_checker dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (AWADDR),
    .S_AXI_AWPROT  (AWPROT),
    .S_AXI_AWVALID (AWVALID),
    .S_AXI_AWREADY (AWREADY),
    .S_AXI_WDATA   (WDATA),
    .S_AXI_WSTRB   (WSTRB),
    .S_AXI_WVALID  (WVALID),
    .S_AXI_WREADY  (WREADY),
    .S_AXI_BRESP   (BRESP),
    .S_AXI_BVALID  (BVALID),
    .S_AXI_BREADY  (BREADY),
    .S_AXI_ARADDR  (ARADDR),
    .S_AXI_ARPROT  (ARPROT),
    .S_AXI_ARVALID (ARVALID),
    .S_AXI_ARREADY (ARREADY),
    .S_AXI_RDATA   (RDATA),
    .S_AXI_RRESP   (RRESP),
    .S_AXI_RVALID  (RVALID),
    .S_AXI_RREADY  (RREADY),
    .S_AXIS_TDATA  (TDATA),
    .S_AXIS_TLAST  (TLAST),
    .S_AXIS_TVALID (TVALID),
    .S_AXIS_TREADY (TREADY)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_en;
  bit          m_cap;
  bit          m_sticky;
  logic [31:0] m_expect;
  longint      m_words;
  longint      m_err;
  longint      m_frames;

  logic [31:0] rd_q[$];
  string       rd_name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake timed out", name);
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_reset();
    m_en = 0; m_cap = 0; m_sticky = 0;
    m_expect = 0; m_words = 0; m_err = 0; m_frames = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    case (a[3:2])
      2'd0: r = {m_sticky, 28'd0, m_cap, 1'b0, m_en};
      2'd1: r = m_expect;
      2'd2: r = 32'(sat(m_words, 64'hFFFF_FFFF));
      default: r = {16'(sat(m_frames, 65535)), 16'(sat(m_err, 65535))};
    endcase
    return r;
  endfunction

  function automatic void model_write(input logic [3:0] a,
                                      input logic [31:0] d,
                                      input logic [3:0] s);
    if (a[3:2] == 2'd0 && s[0]) begin
      m_en  = d[0];
      m_cap = d[2];
      if (d[1]) begin
        m_words = 0; m_err = 0; m_frames = 0; m_sticky = 0;
      end
    end else if (a[3:2] == 2'd1) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_expect[8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  function automatic void model_beat(input logic [31:0] d, input bit last);
    m_words++;
    if (last) m_frames++;
    if (m_cap) begin
      m_expect = d + 1;
    end else if (d != m_expect) begin
      m_err++;
      m_sticky = 1;
      m_expect = d + 1;
    end else begin
      m_expect = m_expect + 1;
    end
  endfunction

  // Scoreboard monitor: one pop per read-data handshake
  always @(negedge ACLK) begin
    #2;
    if (RVALID && RREADY) begin
      if (rd_q.size() == 0) begin
        timeout("rd_unexpected");
      end else begin
        mon_exp  = rd_q.pop_front();
        mon_name = rd_name_q.pop_front();
        check(mon_name, RDATA, mon_exp);
        check({mon_name, "_rresp"}, 32'(RRESP), 32'd0);
      end
    end
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int bhold);
    bit ok = 0;
    @(negedge ACLK);
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = 1; WVALID = 1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (AWREADY && WREADY) begin
        @(posedge ACLK);
        ok = 1;
        break;
      end
      @(negedge ACLK);
    end
    if (ok) model_write(a, d, s);
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    if (!ok) begin
      timeout("aw_w");
      return;
    end
    for (int i = 0; i < bhold; i++) begin
      check("bvalid_hold", 32'(BVALID), 32'd1);
      @(negedge ACLK);
    end
    check("bvalid", 32'(BVALID), 32'd1);
    check("bresp", 32'(BRESP), 32'd0);
    BREADY = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 0;
  endtask

  task automatic axi_read(input logic [3:0] a, input int rhold,
                          input string name);
    bit ok = 0;
    logic [31:0] exp;
    @(negedge ACLK);
    exp = model_read(a);
    ARADDR = a; ARVALID = 1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (ARREADY) begin
        @(posedge ACLK);
        ok = 1;
        break;
      end
      @(negedge ACLK);
    end
    @(negedge ACLK);
    ARVALID = 0;
    if (!ok) begin
      timeout({name, "_ar"});
      return;
    end
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    for (int i = 0; i < rhold; i++) begin
      check({name, "_hold"}, RDATA, exp);
      @(negedge ACLK);
    end
    RREADY = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    RREADY = 0;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last);
    bit ok = 0;
    @(negedge ACLK);
    TDATA = d; TLAST = last; TVALID = 1;
    for (int i = 0; i < 50; i++) begin
      if (TREADY) begin
        @(posedge ACLK);
        ok = 1;
        break;
      end
      @(negedge ACLK);
    end
    if (ok) model_beat(d, last);
    else timeout("beat");
    #1;
    TVALID = 0; TLAST = 0;
  endtask

  task automatic read_all(input string tag);
    axi_read(4'h0, 0, {tag, "_ctrl"});
    axi_read(4'h4, 0, {tag, "_expect"});
    axi_read(4'h8, 0, {tag, "_words"});
    axi_read(4'hC, 0, {tag, "_status"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  s;
    int          op;

    // reset state
    model_reset();
    repeat (3) @(negedge ACLK);
    check("rst_tready", 32'(TREADY), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    ARESET = 0;
    read_all("reset");

    // in-order frame
    axi_write(4'h0, 32'h1, 4'hF, 0);
    check("tready_en", 32'(TREADY), 32'd1);
    axi_write(4'h4, 32'h1, 4'hF, 0);
    for (int i = 1; i <= 8; i++) send_beat(32'(i), i == 8);
    read_all("frame");

    // mismatch and resync
    axi_write(4'h4, 32'h10, 4'hF, 0);
    send_beat(32'h10, 0);
    send_beat(32'h11, 0);
    send_beat(32'h55, 0);
    send_beat(32'h56, 1);
    read_all("resync");

    // expected wraps at 2^32
    axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0);
    send_beat(32'hFFFF_FFFF, 0);
    send_beat(32'h0, 0);
    read_all("wrap");

    // B held off, second AW/W must wait
    axi_write(4'h0, 32'h1, 4'hF, 5);
    @(negedge ACLK);
    AWADDR = 4'h0; WDATA = 32'h1; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1;
    #1;
    check("aw_first", 32'(AWREADY), 32'd1);
    @(posedge ACLK);
    model_write(4'h0, 32'h1, 4'hF);
    #1;
    AWADDR = 4'h4; WDATA = 32'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      #1;
      check("aw_blocked", 32'(AWREADY), 32'd0);
      check("b_pending", 32'(BVALID), 32'd1);
    end
    @(negedge ACLK);
    BREADY = 1;
    @(posedge ACLK);
    #1;
    BREADY = 0;
    @(negedge ACLK);
    #1;
    check("aw_second", 32'(AWREADY), 32'd1);
    @(posedge ACLK);
    model_write(4'h4, 32'h1234, 4'hF);
    #1;
    AWVALID = 0; WVALID = 0;
    @(negedge ACLK);
    check("b_second", 32'(BVALID), 32'd1);
    BREADY = 1;
    @(posedge ACLK);
    #1;
    BREADY = 0;
    axi_read(4'h4, 4, "rd_stable");

    // RO write dropped, partial strobes, unaligned address
    axi_write(4'h8, 32'hDEAD_BEEF, 4'hF, 0);
    axi_write(4'h5, 32'hAABB_CCDD, 4'h3, 1);
    axi_read(4'h9, 0, "ro_words");
    axi_read(4'h6, 0, "strb_expect");

    // clear colliding with an accepted beat
    send_beat(m_expect, 0);
    send_beat(32'h777, 0);
    @(negedge ACLK);
    AWADDR = 4'h0; WDATA = 32'h3; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1;
    TDATA = 32'h999; TLAST = 1; TVALID = 1;
    #1;
    check("clr_aw", 32'(AWREADY), 32'd1);
    check("clr_tready", 32'(TREADY), 32'd1);
    @(posedge ACLK);
    model_write(4'h0, 32'h3, 4'hF);
    #1;
    AWVALID = 0; WVALID = 0; TVALID = 0; TLAST = 0;
    @(negedge ACLK);
    BREADY = 1;
    @(posedge ACLK);
    #1;
    BREADY = 0;
    read_all("clr");

    // EN dropped: TREADY low, counters hold
    axi_write(4'h0, 32'h0, 4'hF, 0);
    @(negedge ACLK);
    TDATA = 32'h5; TVALID = 1;
    repeat (3) begin
      @(negedge ACLK);
      check("tready_off", 32'(TREADY), 32'd0);
    end
    TVALID = 0;
    read_all("disabled");

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 99);
      if (!m_en) begin
        d = {29'($urandom), ($urandom_range(0, 3) == 0), 2'b01};
        axi_write(4'h0, d, 4'hF, $urandom_range(0, 2));
      end else if (op < 60) begin
        d = ($urandom_range(0, 7) == 0) ? $urandom : m_expect;
        send_beat(d, $urandom_range(0, 5) == 0);
      end else if (op < 70) begin
        d = $urandom;
        d[0] = ($urandom_range(0, 4) != 0);
        d[1] = ($urandom_range(0, 9) == 0);
        s = 4'($urandom);
        s[0] = ($urandom_range(0, 3) != 0);
        axi_write({2'd0, 2'($urandom)}, d, s, $urandom_range(0, 3));
      end else if (op < 78) begin
        axi_write({2'd1, 2'($urandom)}, $urandom, 4'($urandom),
                  $urandom_range(0, 2));
      end else if (op < 80) begin
        axi_write({1'b1, 3'($urandom)}, $urandom, 4'hF, 0);
      end else begin
        axi_read(4'($urandom), $urandom_range(0, 3), "rand_rd");
      end
    end
    read_all("random");

    // reset mid-frame
    axi_write(4'h0, 32'h1, 4'hF, 0);
    send_beat(m_expect, 0);
    @(negedge ACLK);
    TDATA = m_expect; TVALID = 1;
    @(posedge ACLK);
    #2;
    ARESET = 1;
    #1;
    check("arst_tready", 32'(TREADY), 32'd0);
    check("arst_rdata", RDATA, 32'd0);
    model_reset();
    TVALID = 0;
    repeat (2) @(negedge ACLK);
    ARESET = 0;
    read_all("arst");

    for (int i = 0; i < 20; i++) begin
      if (rd_q.size() == 0) break;
      @(negedge ACLK);
    end
    if (rd_q.size() != 0) timeout("rd_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_txc_checker.md
Name: axis_txc_checker

Overview:
- AXI4-Stream sink that receives 32-bit TX control words from the txc generator path and checks them against an incrementing expected pattern.
- Counts accepted words, frames and mismatches.
- Exposes control and status through a 4-register AXI4-Lite slave.
- Sits at the far end of the generator stream for loopback self-test and board bring-up.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 4, AXI-Lite byte address width (4 registers)
C_S_AXIS_TDATA_WIDTH, 32, stream data width (only 32 supported)

Ports:
ACLK  in  1  single clock for all interfaces
ARESET  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  always 2'b00 (OKAY)
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00 (OKAY)
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
S_AXIS_TDATA  in  32  stream word
S_AXIS_TLAST  in  1  end of frame
S_AXIS_TVALID / S_AXIS_TREADY  in/out  1  stream handshake

Behaviour:
- Clocking and reset: one clock (ACLK); reset (ARESET) is asynchronous and active-high.
- Reset values: all outputs 0 (AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, TREADY); all registers 0; expected = 0.
- Register map (word aligned; address bits [1:0] ignored):
  - 0x0 CTRL:
    - bit0 EN (RW).
    - bit1 CLR (W1, self-clearing; reads 0).
    - bit2 CAPTURE_ONLY (RW): 1 disables compare.
    - bit31 STICKY_ERR (RO; cleared by CLR).
  - 0x4 EXPECT: RW; the next expected word. A write loads it; a read returns the live value.
  - 0x8 WORD_CNT: RO; words accepted; saturates at 0xFFFFFFFF.
  - 0xC: RO; [15:0] ERR_CNT, [31:16] FRAME_CNT; each saturates at 0xFFFF.
- AXI-Lite write:
  - FSM states W_IDLE and W_RESP.
  - In W_IDLE, when AWVALID&WVALID: AWREADY=WREADY=1 for exactly one cycle, register updated that edge, BVALID=1 next cycle; go to W_RESP.
  - In W_RESP, BVALID holds until BREADY, then return to W_IDLE.
  - AW and W must be presented together; neither is accepted alone.
  - WSTRB is honoured per byte on RW bits.
  - Writes to RO registers are dropped and still get an OKAY response.
- AXI-Lite read:
  - FSM states R_IDLE and R_DATA.
  - In R_IDLE, ARVALID gives ARREADY=1 for one cycle; address latched; RVALID=1 next cycle with RDATA registered.
  - RDATA is held stable until RREADY, then return to R_IDLE.
  - Read and write channels are independent and may complete in the same cycle.
- Stream:
  - TREADY = EN (registered from the CTRL bit; 1-cycle latency after the write).
  - A beat is accepted when TVALID&TREADY.
  - On each accepted beat:
    - WORD_CNT+1.
    - If TLAST: FRAME_CNT+1.
    - If !CAPTURE_ONLY and TDATA!=expected: ERR_CNT+1, STICKY_ERR=1, expected=TDATA+1 (resync).
    - Otherwise: expected = expected+1, with mod 2^32 wrap (0xFFFFFFFF → 0).
  - In CAPTURE_ONLY mode, expected still tracks TDATA+1.
- Simultaneous events:
  - CLR and accept in the same cycle: clear wins and the beat is not counted.
  - EXPECT write and accept in the same cycle: the software value wins.
  - EN cleared mid-frame: TREADY drops next cycle and counters hold.
  - Reset mid-frame: everything returns to reset values immediately.
- Counters never wrap; they stick at their maximum.

Decomposition:
- Package axis_txc_pkg:
  - Register offsets (0x0/0x4/0x8/0xC).
  - CTRL bit indices.
  - RESP_OKAY constant.
  - Counter widths (32/16/16).
  - FSM state encodings.
- Natural sub-module: axis_txc_lite_regs, containing the AXI-Lite FSMs and register file. It exposes ctrl/expect_wr/expect_wdata outputs and status inputs.
- The top holds the stream compare and counters.

Test Plan:
1. Reset release, then read 0x0/0x4/0x8/0xC → all 0x00000000, RESP=OKAY; TREADY=0.
2. Write CTRL=0x1 and EXPECT=0x00000001; send 8 beats 0x01..0x08 with TLAST on the 8th → WORD_CNT=8, 0xC=0x00010000, EXPECT=0x00000009, STICKY_ERR=0.
3. EXPECT=0x10; send 0x10,0x11,0x55,0x56 → ERR_CNT=1, CTRL reads 0x80000001, EXPECT=0x57.
4. EXPECT=0xFFFFFFFF; send 0xFFFFFFFF,0x00000000 → no error, EXPECT=0x00000001.
5. With BREADY held low 5 cycles, write CTRL: BVALID stays high; a second AW/W pair is not accepted until BREADY. With RREADY held low, RDATA stays stable.
6. Write CLR (0x3) in the same cycle as a beat accept → WORD_CNT=0, ERR_CNT=0, STICKY_ERR=0. Assert ARESET mid-frame → TREADY=0 and all registers 0 on the next read.
